pc_fetch_unit: RTL and testbench

Instruction-fetch stage of the pipelined MIPS core: owns the program counter, reads the internal instruction ROM, and produces every value the IF/ID pipeline register latches (instruction, PC, PC+8, branch-delay flag, fetch exception code). It sits ahead of the IF/ID register. It honours the same Stall / ActivateCP0 / CoolCP0 controls, so the two stages redirect in lockstep on hazards, exceptions and eret.

---
 rtl/pc_fetch_unit_if.sv | 29 ++
 rtl/pc_fetch_unit.sv | 59 +++++
 tb/tb_pc_fetch_unit.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_unit_if.sv
// Signal bundle between the fetch stage and its control/pipeline side.
// The fetch unit connects through the slave modport.
interface pc_fetch_unit_if;
  logic        Stall;
  logic        Is_Jump_D;
  logic        Branch_Taken_D;
  logic [31:0] Branch_Target_D;
  logic        ActivateCP0;
  logic        CoolCP0;
  logic [31:0] EPC;
  logic [31:0] Instr_IF;
  logic [31:0] PC_IF;
  logic [31:0] PC8_Out_IF;
  logic        BD_IF;
  logic        AdEL_F;
  logic [4:0]  ExcCode_True_F;

  modport master (
    output Stall, Is_Jump_D, Branch_Taken_D, Branch_Target_D,
           ActivateCP0, CoolCP0, EPC,
    input  Instr_IF, PC_IF, PC8_Out_IF, BD_IF, AdEL_F, ExcCode_True_F
  );

  modport slave (
    input  Stall, Is_Jump_D, Branch_Taken_D, Branch_Target_D,
           ActivateCP0, CoolCP0, EPC,
    output Instr_IF, PC_IF, PC8_Out_IF, BD_IF, AdEL_F, ExcCode_True_F
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// Instruction fetch: PC register, next-PC selection and instruction ROM read.
// ROM contents are supplied at elaboration through the IM_IMAGE parameter.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [31:0] IM_BASE    = 32'h0000_3000,
  parameter int          IM_WORDS   = 4096,
  parameter logic [31:0] IM_IMAGE [IM_WORDS] = '{default: 32'h0}
) (
  input logic           Clk,
  input logic           Rst,
  pc_fetch_unit_if.slave bus
);

  localparam int          AW      = $clog2(IM_WORDS);
  localparam logic [31:0] IM_LAST = IM_BASE + (32'(IM_WORDS) << 2) - 32'd4;

  logic [31:0]   pc;
  logic [31:0]   pc_next;
  logic [31:0]   pc4;
  logic [31:0]   offset;
  logic          adel;
  logic [AW-1:0] rom_idx;

  assign pc4 = pc + 32'd4;

  // Exception entry and eret outrank a stall; a stalled branch is re-presented by ID.
  always_comb begin
    pc_next = pc4;
    if (bus.ActivateCP0)
      pc_next = HANDLER_PC;
    else if (bus.CoolCP0)
      pc_next = bus.EPC;
    else if (bus.Stall)
      pc_next = pc;
    else if (bus.Branch_Taken_D)
      pc_next = bus.Branch_Target_D;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst)
      pc <= RESET_PC;
    else
      pc <= pc_next;
  end

  // Range test on the full address so wrapped or far addresses cannot alias into the ROM.
  assign adel    = (pc[1:0] != 2'b00) || (pc < IM_BASE) || (pc > IM_LAST);
  assign offset  = pc - IM_BASE;
  assign rom_idx = adel ? '0 : AW'(offset >> 2);

  assign bus.Instr_IF       = adel ? 32'h0 : IM_IMAGE[rom_idx];
  assign bus.PC_IF          = pc;
  assign bus.PC8_Out_IF     = pc + 32'd8;
  assign bus.BD_IF          = bus.Is_Jump_D && !bus.CoolCP0;
  assign bus.AdEL_F         = adel;
  assign bus.ExcCode_True_F = adel ? 5'd4 : 5'd0;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: expected fetch outputs are queued as each
// cycle's controls are driven and compared mid-cycle against the DUT.
module tb_pc_fetch_unit;

  localparam logic [31:0] IMG [4096] = '{
    0:      32'h2008_0001,
    1:      32'h2009_0002,
    2:      32'h0109_5020,
    3:      32'hAC0A_0000,
    4:      32'h1000_003B,
    5:      32'h0000_0000,
    8:      32'h3C01_1234,
    'h40:   32'h2010_0040,
    'h41:   32'h2011_0041,
    'h460:  32'h4000_6800,
    'hFFF:  32'hDEAD_BEEF,
    default: 32'h0
  };

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pc8;
    logic [31:0] instr;
    logic        adel;
    logic        bd;
    logic [4:0]  exc;
  } exp_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  logic [31:0] model_pc;
  exp_t sb[$];

  pc_fetch_unit_if bus ();

  pc_fetch_unit #(.IM_IMAGE(IMG)) dut (
    .Clk (clk),
    .Rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic model_adel(input logic [31:0] pc);
    return (pc[1:0] != 2'b00) || (pc < 32'h0000_3000) || (pc > 32'h0000_6FFC);
  endfunction

  function automatic logic [31:0] model_instr(input logic [31:0] pc);
    logic [31:0] idx;
    if (model_adel(pc)) return 32'h0;
    idx = (pc - 32'h0000_3000) >> 2;
    return IMG[idx[11:0]];
  endfunction

  task automatic push_exp();
    exp_t e;
    e.pc    = model_pc;
    e.pc8   = model_pc + 32'd8;
    e.instr = model_instr(model_pc);
    e.adel  = model_adel(model_pc);
    e.bd    = bus.Is_Jump_D && !bus.CoolCP0;
    e.exc   = model_adel(model_pc) ? 5'd4 : 5'd0;
    sb.push_back(e);
  endtask

  task automatic pop_cmp(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_pc"},    bus.PC_IF,                 e.pc);
    chk({tag, "_pc8"},   bus.PC8_Out_IF,            e.pc8);
    chk({tag, "_instr"}, bus.Instr_IF,              e.instr);
    chk({tag, "_adel"},  32'(bus.AdEL_F),           32'(e.adel));
    chk({tag, "_bd"},    32'(bus.BD_IF),            32'(e.bd));
    chk({tag, "_exc"},   32'(bus.ExcCode_True_F),   32'(e.exc));
  endtask

  // One clock cycle: drive controls, queue expectations, compare at negedge, advance model.
  task automatic cyc(input string tag, input logic stall, input logic jump, input logic taken,
                     input logic [31:0] tgt, input logic act, input logic cool,
                     input logic [31:0] epc);
    bus.Stall           = stall;
    bus.Is_Jump_D       = jump;
    bus.Branch_Taken_D  = taken;
    bus.Branch_Target_D = tgt;
    bus.ActivateCP0     = act;
    bus.CoolCP0         = cool;
    bus.EPC             = epc;
    push_exp();
    @(negedge clk);
    pop_cmp(tag);
    @(posedge clk);
    if (act)        model_pc = 32'h0000_4180;
    else if (cool)  model_pc = epc;
    else if (stall) model_pc = model_pc;
    else if (taken) model_pc = tgt;
    else            model_pc = model_pc + 32'd4;
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.Stall = 1'b0; bus.Is_Jump_D = 1'b1; bus.Branch_Taken_D = 1'b0;
    bus.Branch_Target_D = 32'h0; bus.ActivateCP0 = 1'b0; bus.CoolCP0 = 1'b0; bus.EPC = 32'h0;
    model_pc = 32'h0000_3000;
    repeat (2) @(posedge clk);
    #1;
    push_exp();
    pop_cmp("reset");
    rst = 1'b0;

    cyc("run0",   0, 0, 0, 32'h0, 0, 0, 32'h0);
    cyc("run1",   0, 0, 0, 32'h0, 0, 0, 32'h0);
    cyc("stall0", 1, 0, 0, 32'h0, 0, 0, 32'h0);
    cyc("stall1", 1, 0, 0, 32'h0, 0, 0, 32'h0);
    cyc("resume", 0, 0, 0, 32'h0, 0, 0, 32'h0);
    cyc("run3",   0, 0, 0, 32'h0, 0, 0, 32'h0);
    cyc("brstl",  1, 1, 1, 32'h0000_3100, 0, 0, 32'h0);
    cyc("br",     0, 1, 1, 32'h0000_3100, 0, 0, 32'h0);
    cyc("tgt",    0, 0, 0, 32'h0, 0, 0, 32'h0);
    cyc("br3020", 0, 1, 1, 32'h0000_3020, 0, 0, 32'h0);
    cyc("exc",    1, 0, 0, 32'h0, 1, 1, 32'h0000_3002);
    cyc("eret",   0, 1, 0, 32'h0, 0, 1, 32'h0000_3002);
    cyc("epcbad", 0, 0, 0, 32'h0, 0, 0, 32'h0);
    cyc("br7000", 0, 1, 1, 32'h0000_7000, 0, 0, 32'h0);
    cyc("br2ffc", 0, 1, 1, 32'h0000_2FFC, 0, 0, 32'h0);
    cyc("lo_bad", 0, 1, 1, 32'h0000_6FFC, 0, 0, 32'h0);
    cyc("last",   0, 0, 0, 32'h0, 0, 0, 32'h0);
    cyc("past",   0, 1, 1, 32'hFFFF_FFFC, 0, 0, 32'h0);
    cyc("wrap",   0, 0, 0, 32'h0, 0, 0, 32'h0);
    cyc("zero",   0, 1, 1, 32'h0000_3008, 0, 0, 32'h0);
    cyc("back",   0, 0, 0, 32'h0, 0, 0, 32'h0);

    #2;
    rst = 1'b1;
    model_pc = 32'h0000_3000;
    #1;
    push_exp();
    pop_cmp("async_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc("post0", 0, 0, 0, 32'h0, 0, 0, 32'h0);
    cyc("post1", 0, 0, 0, 32'h0, 0, 0, 32'h0);
    cyc("post2", 0, 0, 0, 32'h0, 0, 0, 32'h0);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
